// File: rtl/tlm_stream_pkg.sv
// Shared types and defaults for the byte-streamer transactor stage.
package tlm_stream_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DISCARD,
    DRAIN
  } streamer_state_e;

  localparam int DEFAULT_DEPTH = 256;

endpackage

// File: rtl/tlm_byte_streamer_if.sv
// Load-side and stream-side valid/ready bundle of the byte streamer.
interface tlm_byte_streamer_if
  import tlm_stream_pkg::*;
  ();

  logic  load_valid;
  logic  load_ready;
  byte_t load_data;
  logic  load_last;

  logic  out_valid;
  logic  out_ready;
  byte_t out_data;
  logic  out_last;

  // master is the host/bench side; slave is the streamer itself
  modport master (
    output load_valid, load_data, load_last, out_ready,
    input  load_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  load_valid, load_data, load_last, out_ready,
    output load_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/tlm_pkt_buf.sv
// Packet storage: DEPTH x 8 register array, one sync write port, one async read port.
module tlm_pkt_buf
  import tlm_stream_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  byte_t         wdata,
  input  logic [AW-1:0] raddr,
  output byte_t         rdata
);

  byte_t mem [DEPTH];

  // NOTE: the array has no reset; every byte is written before it is read,
  // so clearing it would only cost a reset fan-out to thousands of flops.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/tlm_byte_streamer.sv
// Buffers a whole loaded packet, then replays it as a valid/ready byte stream.
module tlm_byte_streamer
  import tlm_stream_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int LEN_W = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  tlm_byte_streamer_if.slave  io,
  output logic [LEN_W-1:0]    pkt_len,
  output logic                pkt_done,
  output logic                err_overflow,
  output logic                busy
);

  localparam int AW = $clog2(DEPTH);

  streamer_state_e  state_q, state_nx;
  logic [LEN_W-1:0] wr_cnt_q, wr_cnt_nx;
  logic [LEN_W-1:0] rd_ptr_q, rd_ptr_nx;
  logic [LEN_W-1:0] pkt_len_q, pkt_len_nx;
  logic             load_ready_q, out_valid_q, out_last_q;
  logic             pkt_done_q, err_overflow_q, busy_q;
  logic             ovf_set;
  logic             we;
  logic [AW-1:0]    waddr;
  byte_t            rdata;
  logic             load_hs, out_hs;

  assign load_hs = io.load_valid && load_ready_q;
  assign out_hs  = out_valid_q && io.out_ready;

  tlm_pkt_buf #(.DEPTH(DEPTH), .AW(AW)) u_buf (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (io.load_data),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (rdata)
  );

  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned; otherwise synthesis would infer a latch to hold it.
  always_comb begin
    state_nx   = state_q;
    wr_cnt_nx  = wr_cnt_q;
    rd_ptr_nx  = rd_ptr_q;
    pkt_len_nx = pkt_len_q;
    ovf_set    = 1'b0;
    we         = 1'b0;
    waddr      = wr_cnt_q[AW-1:0];
    case (state_q)
      IDLE: if (load_hs) begin
        we        = 1'b1;
        waddr     = '0;
        wr_cnt_nx = LEN_W'(1);
        if (io.load_last) begin
          state_nx   = DRAIN;
          pkt_len_nx = LEN_W'(1);
        end else begin
          state_nx = FILL;
        end
      end
      FILL: if (load_hs) begin
        we        = 1'b1;
        wr_cnt_nx = wr_cnt_q + LEN_W'(1);
        if (io.load_last) begin
          state_nx   = DRAIN;
          pkt_len_nx = wr_cnt_q + LEN_W'(1);
        end else if (wr_cnt_q == LEN_W'(DEPTH - 1)) begin
          // Buffer is full but the packet keeps coming: keep the first DEPTH bytes.
          state_nx   = DISCARD;
          pkt_len_nx = LEN_W'(DEPTH);
          ovf_set    = 1'b1;
        end
      end
      DISCARD: if (load_hs && io.load_last) state_nx = DRAIN;
      DRAIN: if (out_hs) begin
        if (out_last_q) begin
          state_nx  = IDLE;
          rd_ptr_nx = '0;
          wr_cnt_nx = '0;
        end else begin
          rd_ptr_nx = rd_ptr_q + LEN_W'(1);
        end
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      wr_cnt_q       <= '0;
      rd_ptr_q       <= '0;
      pkt_len_q      <= '0;
      load_ready_q   <= 1'b0;
      out_valid_q    <= 1'b0;
      out_last_q     <= 1'b0;
      pkt_done_q     <= 1'b0;
      err_overflow_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_nx;
      wr_cnt_q       <= wr_cnt_nx;
      rd_ptr_q       <= rd_ptr_nx;
      pkt_len_q      <= pkt_len_nx;
      // Outputs are registered from the next state so they line up with state_q.
      load_ready_q   <= (state_nx != DRAIN);
      out_valid_q    <= (state_nx == DRAIN);
      out_last_q     <= (state_nx == DRAIN) && (rd_ptr_nx == pkt_len_nx - LEN_W'(1));
      busy_q         <= (state_nx == FILL) || (state_nx == DRAIN);
      pkt_done_q     <= (state_q == DRAIN) && out_hs && out_last_q;
      err_overflow_q <= err_overflow_q | ovf_set;
    end
  end

  assign io.load_ready = load_ready_q;
  assign io.out_valid  = out_valid_q;
  assign io.out_last   = out_last_q;
  // Gate the read so stale buffer contents never show outside DRAIN.
  assign io.out_data   = out_valid_q ? rdata : '0;
  assign pkt_len       = pkt_len_q;
  assign pkt_done      = pkt_done_q;
  assign err_overflow  = err_overflow_q;
  assign busy          = busy_q;

endmodule
